// File: rtl/axis_pkt_dump.sv
// AXI4-Stream capture sink: stores whole packets in a dump RAM and only exposes committed packets.
// Read port is a registered RAM read with 1-cycle latency; s_axis_tready is tied high (never stalls).
module axis_pkt_dump #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int ADDR_WIDTH       = 10
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic                          capture_en,
  input  logic                          clear,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_data_valid,
  output logic [AXIS_DATA_WIDTH-1:0]    rd_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  rd_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   rd_tuser,
  output logic                          rd_tlast,
  output logic                          rd_tvalid,
  output logic [ADDR_WIDTH:0]           commit_ptr,
  output logic [ADDR_WIDTH:0]           pkt_count,
  output logic [31:0]                   drop_count,
  output logic                          full
);
  localparam int KEEP_W  = AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_W = 1 + AXIS_TUSER_WIDTH + KEEP_W + AXIS_DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_nxt;
  logic                in_pkt;
  logic                beat, pkt_start;
  logic                wr_en, commit, drop;
  logic [ENTRY_W-1:0]  mem [2**ADDR_WIDTH];

  assign s_axis_tready = 1'b1;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign pkt_start     = beat & ~in_pkt;
  assign full          = (commit_ptr == DEPTH);

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        // Mid-packet beats and unarmed starts fall through untouched.
        if (pkt_start && capture_en) begin
          if (!full) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + (ADDR_WIDTH+1)'(1);
            if (s_axis_tlast) commit = 1'b1;
            else              state_nxt = CAPTURE;
          end else begin
            drop = 1'b1;
            if (!s_axis_tlast) state_nxt = DROP;
          end
        end
      end
      CAPTURE: begin
        if (beat) begin
          if (wr_ptr != DEPTH) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + (ADDR_WIDTH+1)'(1);
            if (s_axis_tlast) begin
              commit    = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            // Overflow: roll back so the partial packet never becomes visible.
            wr_ptr_nxt = commit_ptr;
            drop       = 1'b1;
            state_nxt  = s_axis_tlast ? IDLE : DROP;
          end
        end
      end
      DROP: begin
        if (beat && s_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
      in_pkt     <= 1'b0;
    end else begin
      // Framing tracks the wire even across clear.
      if (beat) in_pkt <= ~s_axis_tlast;
      if (clear) begin
        state      <= IDLE;
        wr_ptr     <= '0;
        commit_ptr <= '0;
        pkt_count  <= '0;
        drop_count <= '0;
      end else begin
        state  <= state_nxt;
        wr_ptr <= wr_ptr_nxt;
        if (commit) begin
          commit_ptr <= wr_ptr_nxt;
          pkt_count  <= pkt_count + (ADDR_WIDTH+1)'(1);
        end
        if (drop && (drop_count != 32'hFFFF_FFFF)) drop_count <= drop_count + 32'd1;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_resetn && wr_en && !clear)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      rd_data_valid <= 1'b0;
      rd_tvalid     <= 1'b0;
      rd_tlast      <= 1'b0;
      rd_tuser      <= '0;
      rd_tkeep      <= '0;
      rd_tdata      <= '0;
    end else begin
      rd_data_valid <= rd_en;
      if (rd_en) begin
        {rd_tlast, rd_tuser, rd_tkeep, rd_tdata} <= mem[rd_addr];
        rd_tvalid <= ({1'b0, rd_addr} < commit_ptr);
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_dump.sv
// Bench for axis_pkt_dump: directed vector table, hand-written corner sequences,
// and randomized traffic against a packet-level queue model.
module tb_axis_pkt_dump;
  localparam int DW = 64;
  localparam int UW = 16;
  localparam int KW = DW / 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [KW-1:0] tkeep = '0;
  logic [UW-1:0] tuser = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          tlast = 1'b0;
  logic          capture_en = 1'b1;
  logic          clear = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_data_valid;
  logic [DW-1:0] rd_tdata;
  logic [KW-1:0] rd_tkeep;
  logic [UW-1:0] rd_tuser;
  logic          rd_tlast;
  logic          rd_tvalid;
  logic [AW:0]   commit_ptr;
  logic [AW:0]   pkt_count;
  logic [31:0]   drop_count;
  logic          full;

  axis_pkt_dump #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .ADDR_WIDTH(AW)) dut (
    .axis_aclk(clk), .axis_resetn(resetn),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .capture_en(capture_en), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_valid(rd_data_valid),
    .rd_tdata(rd_tdata), .rd_tkeep(rd_tkeep), .rd_tuser(rd_tuser),
    .rd_tlast(rd_tlast), .rd_tvalid(rd_tvalid),
    .commit_ptr(commit_ptr), .pkt_count(pkt_count), .drop_count(drop_count), .full(full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: committed packets live in m_mem[0..m_commit-1]; the packet
  // being received sits in m_pend until its last beat decides commit or drop.
  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } ent_t;

  ent_t        m_mem [DEPTH];
  ent_t        m_pend [$];
  int          m_commit = 0;
  int          m_pkt = 0;
  logic [31:0] m_drop = '0;
  bit          m_in_pkt = 0;
  bit          m_collect = 0;
  bit          m_rd_dv = 0;
  bit          m_rd_tv = 0;
  bit          m_rd_known = 0;
  ent_t        m_rd_ent;

  task automatic bump_drop();
    if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
  endtask

  task automatic commit_pend();
    foreach (m_pend[i]) m_mem[m_commit + i] = m_pend[i];
    m_commit += m_pend.size();
    m_pkt++;
    m_pend.delete();
    m_collect = 0;
  endtask

  // Apply the currently driven inputs for one clock, advance the model, check.
  task automatic step();
    ent_t e;
    e.last = tlast; e.user = tuser; e.keep = tkeep; e.data = tdata;
    m_rd_dv = rd_en;
    if (rd_en) begin
      m_rd_tv    = (int'(rd_addr) < m_commit);
      m_rd_known = m_rd_tv;
      if (m_rd_tv) m_rd_ent = m_mem[rd_addr];
    end
    if (clear) begin
      m_commit = 0; m_pkt = 0; m_drop = '0; m_pend.delete(); m_collect = 0;
    end else if (tvalid) begin
      if (!m_in_pkt) begin
        m_collect = 0;
        if (capture_en) begin
          if (m_commit == DEPTH) bump_drop();
          else begin
            m_pend.delete();
            m_pend.push_back(e);
            m_collect = 1;
            if (tlast) commit_pend();
          end
        end
      end else if (m_collect) begin
        if (m_commit + m_pend.size() < DEPTH) begin
          m_pend.push_back(e);
          if (tlast) commit_pend();
        end else begin
          m_pend.delete();
          m_collect = 0;
          bump_drop();
        end
      end
    end
    if (tvalid) m_in_pkt = !tlast;
    @(posedge clk); #1;
    chk("commit_ptr", 64'(commit_ptr), 64'(m_commit));
    chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("full", 64'(full), 64'(m_commit == DEPTH));
    chk("tready", 64'(tready), 64'd1);
    chk("rd_data_valid", 64'(rd_data_valid), 64'(m_rd_dv));
    chk("rd_tvalid", 64'(rd_tvalid), 64'(m_rd_tv));
    if (m_rd_known) begin
      chk("rd_tdata", rd_tdata, m_rd_ent.data);
      chk("rd_tkeep", 64'(rd_tkeep), 64'(m_rd_ent.keep));
      chk("rd_tuser", 64'(rd_tuser), 64'(m_rd_ent.user));
      chk("rd_tlast", 64'(rd_tlast), 64'(m_rd_ent.last));
    end
  endtask

  task automatic idle_inputs();
    tvalid = 0; tlast = 0; clear = 0; rd_en = 0;
  endtask

  task automatic rand_beat_data();
    tdata = {$urandom, $urandom};
    tkeep = KW'($urandom);
    tuser = UW'($urandom);
  endtask

  // Send an n-beat packet back to back; capture_en per beat from cap_mask (bit i
  // = beat i); clear pulses with beat clr_at (-1 for none).
  task automatic send_pkt(input int n, input logic [15:0] cap_mask, input int clr_at);
    for (int i = 0; i < n; i++) begin
      rand_beat_data();
      tvalid = 1; tlast = (i == n - 1);
      capture_en = cap_mask[i];
      clear = (i == clr_at);
      step();
    end
    idle_inputs();
    capture_en = 1;
  endtask

  typedef struct {
    bit            vld, last, rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            e_commit, e_pkt;
    bit            e_rdv, e_rtv, e_chkdata, e_rlast;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vt [8];
  logic [DW-1:0] saved;

  initial begin
    vt[0] = '{1,0,0,4'd0,64'hA0, 0,0, 0,0,0,0,64'h0};
    vt[1] = '{1,0,0,4'd0,64'hA1, 0,0, 0,0,0,0,64'h0};
    vt[2] = '{1,1,0,4'd0,64'hA2, 3,1, 0,0,0,0,64'h0};
    vt[3] = '{0,0,1,4'd0,64'h0,  3,1, 1,1,1,0,64'hA0};
    vt[4] = '{0,0,1,4'd1,64'h0,  3,1, 1,1,1,0,64'hA1};
    vt[5] = '{0,0,1,4'd2,64'h0,  3,1, 1,1,1,1,64'hA2};
    vt[6] = '{0,0,1,4'd3,64'h0,  3,1, 1,0,0,0,64'h0};
    vt[7] = '{0,0,0,4'd0,64'h0,  3,1, 0,0,0,0,64'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst commit_ptr", 64'(commit_ptr), 64'd0);
    chk("rst pkt_count", 64'(pkt_count), 64'd0);
    chk("rst drop_count", 64'(drop_count), 64'd0);
    chk("rst full", 64'(full), 64'd0);
    chk("rst rd_data_valid", 64'(rd_data_valid), 64'd0);
    chk("rst rd_tvalid", 64'(rd_tvalid), 64'd0);
    chk("rst rd_tdata", rd_tdata, 64'd0);
    chk("rst tready", 64'(tready), 64'd1);
    resetn = 1;
    step();

    // 1: 3-beat packet then read back through the vector table
    foreach (vt[i]) begin
      tvalid = vt[i].vld; tlast = vt[i].last; tdata = vt[i].data;
      tkeep = '1; tuser = '0; capture_en = 1;
      rd_en = vt[i].rd; rd_addr = vt[i].addr;
      step();
      chk("vec commit_ptr", 64'(commit_ptr), 64'(vt[i].e_commit));
      chk("vec pkt_count", 64'(pkt_count), 64'(vt[i].e_pkt));
      chk("vec rd_data_valid", 64'(rd_data_valid), 64'(vt[i].e_rdv));
      chk("vec rd_tvalid", 64'(rd_tvalid), 64'(vt[i].e_rtv));
      if (vt[i].e_chkdata) begin
        chk("vec rd_tdata", rd_tdata, vt[i].e_rdata);
        chk("vec rd_tlast", 64'(rd_tlast), 64'(vt[i].e_rlast));
      end
    end
    idle_inputs();

    // 2: overflow rollback, then fill to exactly full
    clear = 1; step(); clear = 0;
    send_pkt(10, 16'hFFFF, -1);
    chk("t2 commit after 10", 64'(commit_ptr), 64'd10);
    send_pkt(8, 16'hFFFF, -1);
    chk("t2 commit after ovf", 64'(commit_ptr), 64'd10);
    chk("t2 drop after ovf", 64'(drop_count), 64'd1);
    chk("t2 full after ovf", 64'(full), 64'd0);
    send_pkt(6, 16'hFFFF, -1);
    chk("t2 commit filled", 64'(commit_ptr), 64'd16);
    chk("t2 full", 64'(full), 64'd1);
    chk("t2 pkt_count", 64'(pkt_count), 64'd2);

    // 3: packet arriving while full
    send_pkt(2, 16'hFFFF, -1);
    chk("t3 drop", 64'(drop_count), 64'd2);
    chk("t3 commit", 64'(commit_ptr), 64'd16);
    chk("t3 tready", 64'(tready), 64'd1);

    // 4: capture_en changing mid-packet
    clear = 1; step(); clear = 0;
    send_pkt(4, 16'hFFFE, -1);
    chk("t4 late arm commit", 64'(commit_ptr), 64'd0);
    chk("t4 late arm drop", 64'(drop_count), 64'd0);
    send_pkt(4, 16'h0001, -1);
    chk("t4 early disarm commit", 64'(commit_ptr), 64'd4);
    chk("t4 early disarm pkts", 64'(pkt_count), 64'd1);

    // 5: clear in the middle of a packet
    send_pkt(5, 16'hFFFF, 2);
    chk("t5 commit", 64'(commit_ptr), 64'd0);
    chk("t5 pkt_count", 64'(pkt_count), 64'd0);
    chk("t5 drop", 64'(drop_count), 64'd0);
    send_pkt(1, 16'hFFFF, -1);
    saved = tdata;
    chk("t5 commit one", 64'(commit_ptr), 64'd1);
    rd_en = 1; rd_addr = '0; step(); rd_en = 0;
    chk("t5 entry0 data", rd_tdata, saved);
    chk("t5 entry0 valid", 64'(rd_tvalid), 64'd1);
    chk("t5 entry0 last", 64'(rd_tlast), 64'd1);

    // 6: randomized traffic with a read every cycle sweeping all addresses
    clear = 1; step(); clear = 0;
    begin
      int rem = 0;
      for (int c = 0; c < 1500; c++) begin
        rd_en = 1;
        rd_addr = AW'(c);
        clear = ($urandom_range(0, 69) == 0);
        if ($urandom_range(0, 9) == 0) capture_en = ~capture_en;
        else if ($urandom_range(0, 3) == 0) capture_en = 1;
        if ($urandom_range(0, 3) != 0) begin
          if (rem == 0) rem = $urandom_range(1, 7);
          rand_beat_data();
          tvalid = 1; tlast = (rem == 1);
          rem--;
        end else begin
          tvalid = 0; tlast = 0;
        end
        step();
      end
      // Finish the packet in flight so the stream ends on a boundary.
      while (rem > 0) begin
        rand_beat_data();
        clear = 0; rd_en = 0;
        tvalid = 1; tlast = (rem == 1);
        rem--;
        step();
      end
    end
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
